// File: rtl/fmap_addr_gen_l9_if.sv
// fmap_addr_gen_l9_if -- bus between the layer-9 temp counter / memory side
// and the feature-map address generator.
//   master : drives start and the three temp-counter strobes, observes outputs
//   slave  : the address generator (consumes strobes, drives addresses/status)
interface fmap_addr_gen_l9_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic              temp_6;
    logic              temp_zero;
    logic              temp_zero_new;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        col;
    logic [3:0]        row;
    logic [2:0]        ch;
    logic              busy;
    logic              done;

    modport master (
        output start, temp_6, temp_zero, temp_zero_new,
        input  rd_valid, rd_addr, wr_valid, wr_addr, col, row, ch, busy, done
    );

    modport slave (
        input  start, temp_6, temp_zero, temp_zero_new,
        output rd_valid, rd_addr, wr_valid, wr_addr, col, row, ch, busy, done
    );
endinterface

// File: rtl/fmap_addr_gen_l9.sv
// fmap_addr_gen_l9 -- address generator for one layer-9 feature-map pass.
// Walks col/row/ch over COLS x ROWS x CHS windows, keeping a linear index
// that is incremented rather than computed, and turns the temp-counter
// strobes into one-cycle read/write address pulses.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   bus      : slave side of fmap_addr_gen_l9_if
//              start                     - begin a pass (honoured in IDLE only)
//              temp_6 / temp_zero        - capture read / write address
//              temp_zero_new             - advance to next window
//              rd_valid/rd_addr          - read address pulse
//              wr_valid/wr_addr          - write address pulse
//              col/row/ch, busy, done    - position and status
module fmap_addr_gen_l9 #(
    parameter int COLS     = 14,
    parameter int ROWS     = 14,
    parameter int CHS      = 8,
    parameter int ADDR_W   = 12,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    fmap_addr_gen_l9_if.slave     bus
);
    localparam int TOTAL = COLS * ROWS * CHS;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         col_q, row_q;
    logic [2:0]         ch_q;
    logic [IDX_W-1:0]   idx_q;
    logic               rd_valid_q, wr_valid_q;
    logic [ADDR_W-1:0]  rd_addr_q, wr_addr_q;

    logic col_last, row_last, ch_last;
    logic advance, pass_end;

    always_comb begin
        col_last = (col_q == 4'(COLS - 1));
        row_last = (row_q == 4'(ROWS - 1));
        ch_last  = (ch_q  == 3'(CHS - 1));
        advance  = (state_q == RUN) && bus.temp_zero_new;
        pass_end = advance && col_last && row_last && ch_last;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (pass_end)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Captures use idx_q before this edge's advance, so a capture strobe
    // coinciding with temp_zero_new sees the current window's address.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            ch_q       <= '0;
            idx_q      <= '0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
        end else begin
            rd_valid_q <= (state_q == RUN) && bus.temp_6;
            wr_valid_q <= (state_q == RUN) && bus.temp_zero;
            if ((state_q == RUN) && bus.temp_6)
                rd_addr_q <= ADDR_W'(IN_BASE) + ADDR_W'(idx_q);
            if ((state_q == RUN) && bus.temp_zero)
                wr_addr_q <= ADDR_W'(OUT_BASE) + ADDR_W'(idx_q);

            if ((state_q == IDLE) && bus.start) begin
                col_q <= '0;
                row_q <= '0;
                ch_q  <= '0;
                idx_q <= '0;
            end else if (pass_end) begin
                // TOTAL is generally not a power of two, so idx needs an
                // explicit wrap along with the counters.
                col_q <= '0;
                row_q <= '0;
                ch_q  <= '0;
                idx_q <= '0;
            end else if (advance) begin
                idx_q <= idx_q + 1'b1;
                if (col_last) begin
                    col_q <= '0;
                    if (row_last) begin
                        row_q <= '0;
                        ch_q  <= ch_q + 1'b1;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.col      = col_q;
    assign bus.row      = row_q;
    assign bus.ch       = ch_q;
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_fmap_addr_gen_l9.sv
// tb_fmap_addr_gen_l9 -- directed bench for fmap_addr_gen_l9 with default
// parameters (14x14x8, ADDR_W 12, IN_BASE 0, OUT_BASE 2048).
module tb_fmap_addr_gen_l9;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    fmap_addr_gen_l9_if #(.ADDR_W(12)) bus ();

    fmap_addr_gen_l9 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        bus.start = 1'b0; bus.temp_6 = 1'b0;
        bus.temp_zero = 1'b0; bus.temp_zero_new = 1'b0;
    endtask

    task automatic windows(input int n);
        for (int i = 0; i < n; i++) begin
            bus.temp_zero_new = 1'b1;
            tick();
            bus.temp_zero_new = 1'b0;
        end
    endtask

    task automatic test_reset;
        logic [38:0] o;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.start = 1'b1; bus.temp_6 = i[0]; bus.temp_zero = 1'b1; bus.temp_zero_new = 1'b1;
            tick();
            o = {bus.rd_valid, bus.rd_addr, bus.wr_valid, bus.wr_addr, bus.col, bus.row, bus.ch, bus.busy, bus.done};
            nvec++;
            if (o !== 39'd0) begin errs++; $display("FAIL reset_hold: outputs=%h required 0", o); end
        end
        rst = 1'b0;
        clr_in();
        for (int i = 0; i < 5; i++) begin
            bus.temp_6 = i[0]; bus.temp_zero = i[1]; bus.temp_zero_new = ~i[0];
            tick();
            o = {bus.rd_valid, bus.rd_addr, bus.wr_valid, bus.wr_addr, bus.col, bus.row, bus.ch, bus.busy, bus.done};
            nvec++;
            if (o !== 39'd0) begin errs++; $display("FAIL idle_strobes[%0d]: outputs=%h required 0", i, o); end
        end
        clr_in();
    endtask

    task automatic test_first_window;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        nvec++;
        if (bus.busy !== 1'b1 || bus.col !== 4'd0) begin
            errs++; $display("FAIL start_busy: busy=%b col=%0d required busy=1 col=0", bus.busy, bus.col);
        end
        bus.temp_6 = 1'b1; tick(); bus.temp_6 = 1'b0;
        nvec++;
        if (bus.rd_valid !== 1'b1 || bus.rd_addr !== 12'd0) begin
            errs++; $display("FAIL first_rd: rd_valid=%b rd_addr=%0d required 1/0", bus.rd_valid, bus.rd_addr);
        end
        tick();
        nvec++;
        if (bus.rd_valid !== 1'b0 || bus.rd_addr !== 12'd0) begin
            errs++; $display("FAIL rd_pulse_len: rd_valid=%b rd_addr=%0d required 0/0", bus.rd_valid, bus.rd_addr);
        end
        bus.temp_zero = 1'b1; tick(); bus.temp_zero = 1'b0;
        nvec++;
        if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 12'd2048) begin
            errs++; $display("FAIL first_wr: wr_valid=%b wr_addr=%0d required 1/2048", bus.wr_valid, bus.wr_addr);
        end
        windows(1);
        nvec++;
        if (bus.col !== 4'd1 || bus.row !== 4'd0 || bus.wr_valid !== 1'b0) begin
            errs++; $display("FAIL first_adv: col=%0d row=%0d wr_valid=%b required 1/0/0", bus.col, bus.row, bus.wr_valid);
        end
        bus.temp_6 = 1'b1; tick(); bus.temp_6 = 1'b0;
        nvec++;
        if (bus.rd_addr !== 12'd1) begin
            errs++; $display("FAIL idx_one: rd_addr=%0d required 1", bus.rd_addr);
        end
    endtask

    // idx is 1 on entry
    task automatic test_same_cycle;
        windows(4);
        bus.temp_6 = 1'b1; bus.temp_zero_new = 1'b1; tick(); clr_in();
        nvec++;
        if (bus.rd_valid !== 1'b1 || bus.rd_addr !== 12'd5 || bus.col !== 4'd6) begin
            errs++; $display("FAIL same_cycle: rd_valid=%b rd_addr=%0d col=%0d required 1/5/6", bus.rd_valid, bus.rd_addr, bus.col);
        end
        bus.temp_6 = 1'b1; tick(); bus.temp_6 = 1'b0;
        nvec++;
        if (bus.rd_addr !== 12'd6) begin
            errs++; $display("FAIL after_same: rd_addr=%0d required 6", bus.rd_addr);
        end
    endtask

    // idx is 6 on entry
    task automatic test_row_wrap;
        windows(8);
        nvec++;
        if (bus.col !== 4'd0 || bus.row !== 4'd1 || bus.ch !== 3'd0) begin
            errs++; $display("FAIL row_wrap: col=%0d row=%0d ch=%0d required 0/1/0", bus.col, bus.row, bus.ch);
        end
        bus.temp_6 = 1'b1; tick(); bus.temp_6 = 1'b0;
        nvec++;
        if (bus.rd_addr !== 12'd14) begin
            errs++; $display("FAIL win15_rd: rd_addr=%0d required 14", bus.rd_addr);
        end
    endtask

    // idx is 14 on entry
    task automatic test_reset_mid;
        logic [38:0] o;
        windows(86);
        nvec++;
        if (bus.col !== 4'd2 || bus.row !== 4'd7 || bus.busy !== 1'b1) begin
            errs++; $display("FAIL idx100_pos: col=%0d row=%0d busy=%b required 2/7/1", bus.col, bus.row, bus.busy);
        end
        rst = 1'b1; bus.start = 1'b1; bus.temp_6 = 1'b1; bus.temp_zero = 1'b1; bus.temp_zero_new = 1'b1;
        tick();
        rst = 1'b0; bus.start = 1'b0;
        o = {bus.rd_valid, bus.rd_addr, bus.wr_valid, bus.wr_addr, bus.col, bus.row, bus.ch, bus.busy, bus.done};
        nvec++;
        if (o !== 39'd0) begin errs++; $display("FAIL mid_reset: outputs=%h required 0", o); end
        tick();
        clr_in();
        o = {bus.rd_valid, bus.rd_addr, bus.wr_valid, bus.wr_addr, bus.col, bus.row, bus.ch, bus.busy, bus.done};
        nvec++;
        if (o !== 39'd0) begin errs++; $display("FAIL post_reset: outputs=%h required 0", o); end
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.temp_6 = 1'b1; tick(); bus.temp_6 = 1'b0;
        nvec++;
        if (bus.rd_valid !== 1'b1 || bus.rd_addr !== 12'd0 || bus.busy !== 1'b1) begin
            errs++; $display("FAIL restart: rd_valid=%b rd_addr=%0d busy=%b required 1/0/1", bus.rd_valid, bus.rd_addr, bus.busy);
        end
    endtask

    // RUN at idx 0 on entry; each window writes and advances in the same cycle
    task automatic test_full_pass;
        int dn = 0;
        int early = 0;
        for (int i = 0; i < 1568; i++) begin
            bus.temp_zero = 1'b1; bus.temp_zero_new = 1'b1;
            tick();
            if (bus.done === 1'b1) begin
                dn++;
                if (i != 1567) early++;
            end
        end
        clr_in();
        nvec++;
        if (dn != 1 || early != 0) begin
            errs++; $display("FAIL done_count: pulses=%0d early=%0d required 1/0", dn, early);
        end
        nvec++;
        if (bus.col !== 4'd0 || bus.row !== 4'd0 || bus.ch !== 3'd0 || bus.busy !== 1'b0) begin
            errs++; $display("FAIL pass_wrap: col=%0d row=%0d ch=%0d busy=%b required 0/0/0/0", bus.col, bus.row, bus.ch, bus.busy);
        end
        nvec++;
        if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 12'd3615) begin
            errs++; $display("FAIL final_wr: wr_valid=%b wr_addr=%0d required 1/3615", bus.wr_valid, bus.wr_addr);
        end
        // start and strobe during DONE are ignored
        bus.start = 1'b1; bus.temp_6 = 1'b1; tick(); clr_in();
        nvec++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.wr_valid !== 1'b0) begin
            errs++; $display("FAIL done_exit: done=%b busy=%b rd_valid=%b wr_valid=%b required 0/0/0/0", bus.done, bus.busy, bus.rd_valid, bus.wr_valid);
        end
        bus.temp_zero_new = 1'b1; bus.temp_zero = 1'b1; tick(); tick(); clr_in();
        nvec++;
        if (bus.col !== 4'd0 || bus.busy !== 1'b0 || bus.wr_valid !== 1'b0 || bus.wr_addr !== 12'd3615 || bus.rd_addr !== 12'd0) begin
            errs++; $display("FAIL idle_hold: col=%0d busy=%b wr_valid=%b wr_addr=%0d rd_addr=%0d required 0/0/0/3615/0",
                             bus.col, bus.busy, bus.wr_valid, bus.wr_addr, bus.rd_addr);
        end
    endtask

    initial begin
        clr_in();
        test_reset();
        test_first_window();
        test_same_cycle();
        test_row_wrap();
        test_reset_mid();
        test_full_pass();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
